// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: states, instruction classes, opcode/funct3 values.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    RTYPE   = 3'd0,
    ADDI    = 3'd1,
    LD      = 3'd2,
    SD      = 3'd3,
    ILLEGAL = 3'd4
  } class_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_DW  = 3'b011;

endpackage

// File: rtl/control_unit_classifier.sv
// Combinational opcode/funct3 decoder; anything outside the supported subset maps to ILLEGAL.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output class_e     instr_class
);

  always_comb begin
    instr_class = ILLEGAL;
    case (opcode)
      OP_RTYPE: if (funct3 == F3_ADD) instr_class = RTYPE;
      OP_ADDI:  if (funct3 == F3_ADD) instr_class = ADDI;
      OP_LD:    if (funct3 == F3_DW)  instr_class = LD;
      OP_SD:    if (funct3 == F3_DW)  instr_class = SD;
      default:  instr_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: INIT/FETCH/DECODE/EXEC/[MEM]/WB, sticky HALT on illegal opcodes.
// MEM stalls indefinitely on mem_ready=0; only sd's MEM exit (load_pc) looks at mem_ready combinationally.
module control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 mem_ready,
  output logic                 load_ir,
  output logic                 load_pc,
  output logic                 reset_pc,
  output logic                 sub,
  output logic                 ULA_din2_sel,
  output logic                 RF_din_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  class_e                 class_q, class_d;
  logic                   sub_q, sub_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  class_e                 dec_class;

  opcode_classifier u_classifier (
    .opcode      (opcode),
    .funct3      (funct3),
    .instr_class (dec_class)
  );

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    sub_d        = sub_q;
    instret_d    = instret_q;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    reset_pc     = 1'b0;
    sub          = 1'b0;
    ULA_din2_sel = 1'b0;
    RF_din_sel   = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    halted       = 1'b0;

    // ALU operand selection stays stable from EXEC until the instruction retires.
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      sub          = sub_q;
      ULA_din2_sel = (class_q != RTYPE);
    end

    case (state_q)
      INIT: begin
        reset_pc = 1'b1;
        state_d  = FETCH;
      end
      FETCH: begin
        load_ir = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        class_d = dec_class;
        sub_d   = funct7_5 && (dec_class == RTYPE);
        state_d = (dec_class == ILLEGAL) ? HALT : EXEC;
      end
      EXEC: begin
        state_d = (class_q == LD || class_q == SD) ? MEM : WB;
      end
      MEM: begin
        if (class_q == SD) begin
          WE_MEM = 1'b1;
          if (mem_ready) begin
            load_pc   = 1'b1;
            instret_d = instret_q + INSTRET_ONE;
            state_d   = FETCH;
          end
        end else if (mem_ready) begin
          state_d = WB;
        end
      end
      WB: begin
        WE_RF      = 1'b1;
        RF_din_sel = (class_q != LD);
        load_pc    = 1'b1;
        instret_d  = instret_q + INSTRET_ONE;
        state_d    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT;
      class_q   <= RTYPE;
      sub_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      sub_q     <= sub_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expectations queued as stimulus is driven, checked each cycle.
module tb_control_unit;

  localparam int W = 4;
  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0;
  logic mem_ready = 1'b1;
  logic load_ir, load_pc, reset_pc, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, halted;
  logic [W-1:0] instret;
  logic [2:0] state;

  control_unit #(.INSTRET_W(W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .sub(sub), .ULA_din2_sel(ULA_din2_sel), .RF_din_sel(RF_din_sel), .WE_RF(WE_RF),
    .WE_MEM(WE_MEM), .halted(halted), .instret(instret), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]   st;
    logic [8:0]   o;
    logic [W-1:0] ir;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] m_ir = '0;

  // Output vector order: load_ir, load_pc, reset_pc, sub, din2_sel, rf_din_sel, we_rf, we_mem, halted
  function automatic logic [8:0] outs(input logic lir, lpc, rpc, sb_, d2, rfs, werf, wem, hlt);
    return {lir, lpc, rpc, sb_, d2, rfs, werf, wem, hlt};
  endfunction

  task automatic push(input logic [2:0] st, input logic [8:0] o);
    exp_t e;
    e.st = st;
    e.o  = o;
    e.ir = m_ir;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic mr, input string tag);
    exp_t e;
    logic [8:0] act;
    @(negedge CLK);
    RST = rst;
    mem_ready = mr;
    #1;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard: got empty queue want entry", tag);
    end else begin
      e = sb.pop_front();
      act = {load_ir, load_pc, reset_pc, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, halted};
      vectors++;
      assert (state === e.st) else begin
        miscompares++;
        $error("FAIL %s state: got %0d want %0d", tag, state, e.st);
      end
      assert (act === e.o) else begin
        miscompares++;
        $error("FAIL %s outputs: got %b want %b", tag, act, e.o);
      end
      assert (instret === e.ir) else begin
        miscompares++;
        $error("FAIL %s instret: got %0d want %0d", tag, instret, e.ir);
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int stalls, input logic rst_in_mem, input string tag);
    logic r, a, l, s, ill, sb_, d2;
    r   = (op == 7'b0110011) && (f3 == 3'b000);
    a   = (op == 7'b0010011) && (f3 == 3'b000);
    l   = (op == 7'b0000011) && (f3 == 3'b011);
    s   = (op == 7'b0100011) && (f3 == 3'b011);
    ill = !(r || a || l || s);
    opcode = op;
    funct3 = f3;
    funct7_5 = f7;
    push(S_FETCH, outs(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, tag);
    push(S_DECODE, outs(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, tag);
    // Scramble the instruction inputs once DECODE has been captured.
    @(posedge CLK);
    #1;
    opcode = 7'b1111111;
    funct3 = 3'b111;
    funct7_5 = ~f7;
    if (ill) begin
      repeat (3) begin
        push(S_HALT, outs(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b1, tag);
      end
      return;
    end
    sb_ = r && f7;
    d2  = !r;
    push(S_EXEC, outs(0, 0, 0, sb_, d2, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, tag);
    if (l || s) begin
      for (int i = 0; i < stalls; i++) begin
        push(S_MEM, outs(0, 0, 0, sb_, d2, 0, 0, s, 0));
        cyc(1'b0, 1'b0, tag);
      end
      if (rst_in_mem) begin
        push(S_MEM, outs(0, 0, 0, sb_, d2, 0, 0, s, 0));
        cyc(1'b1, 1'b0, tag);
        m_ir = '0;
        push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b0, tag);
        return;
      end
      push(S_MEM, outs(0, s, 0, sb_, d2, 0, 0, s, 0));
      cyc(1'b0, 1'b1, tag);
      if (s) begin
        m_ir++;
        return;
      end
    end
    push(S_WB, outs(0, 1, 0, sb_, d2, !l, 1, 0, 0));
    cyc(1'b0, 1'b1, tag);
    m_ir++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 1'b1, "reset_hold");
    push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, "reset_release");

    run_instr(7'b0110011, 3'b000, 1'b0, 0, 1'b0, "add");
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 1'b0, "sub");
    run_instr(7'b0010011, 3'b000, 1'b0, 0, 1'b0, "addi");
    run_instr(7'b0000011, 3'b011, 1'b1, 3, 1'b0, "ld_stall3");
    run_instr(7'b0100011, 3'b011, 1'b0, 0, 1'b0, "sd");
    run_instr(7'b0100011, 3'b011, 1'b0, 2, 1'b0, "sd_stall2");
    run_instr(7'b0010011, 3'b001, 1'b0, 0, 1'b0, "addi_bad_f3");

    push(S_HALT, outs(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(1'b1, 1'b1, "halt_rst");
    m_ir = '0;
    push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 1'b1, "halt_rst_hold");
    push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, "halt_rst_release");

    run_instr(7'b1100011, 3'b000, 1'b0, 0, 1'b0, "branch_illegal");
    push(S_HALT, outs(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(1'b1, 1'b1, "halt2_rst");
    m_ir = '0;
    push(S_INIT, outs(0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, "halt2_release");

    run_instr(7'b0010011, 3'b000, 1'b0, 0, 1'b0, "pre_stall_addi");
    run_instr(7'b0000011, 3'b011, 1'b0, 2, 1'b1, "ld_rst_in_mem");

    for (int i = 0; i < 16; i++) begin
      run_instr(7'b0010011, 3'b000, 1'b0, 0, 1'b0, "wrap_addi");
    end
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 1'b0, "post_wrap_sub");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_scoreboard: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
